// File: rtl/mul_unit.sv
// Multi-cycle 32x32 MULT/MULTU controller for the EX stage: operand magnitudes,
// unsigned array multiply, sign fix-up. Define MUL_PIPE_EN to register the array output (3-cycle latency).
module mul (
  input  logic [31:0] ina,
  input  logic [31:0] inb,
  output logic [63:0] out
);
  assign out = 64'(ina) * 64'(inb);
endmodule

module mul_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);
  typedef enum logic [1:0] {IDLE, ARR, FIX, DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic        neg_q;
  logic [63:0] result_q;
  logic [63:0] mul_out;
  logic [63:0] fix_in;
  logic        accept;

  // 0x80000000 maps to itself: as an unsigned 32-bit magnitude it is exact.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  mul u_mul (
    .ina (a_q),
    .inb (b_q),
    .out (mul_out)
  );

`ifdef MUL_PIPE_EN
  logic [63:0] prod_q;
  assign fix_in = prod_q;
`else
  assign fix_in = mul_out;
`endif

  assign accept = (state_q == IDLE) && start_i && !annul_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
`ifdef MUL_PIPE_EN
      prod_q   <= '0;
`endif
    end else if (annul_i) begin
      // Flush discards the in-flight operation; result_q keeps its last value.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          a_q   <= magnitude(opdata1_i, signed_i);
          b_q   <= magnitude(opdata2_i, signed_i);
          neg_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
`ifdef MUL_PIPE_EN
          state_q <= ARR;
`else
          state_q <= FIX;
`endif
        end
`ifdef MUL_PIPE_EN
        ARR: begin
          prod_q  <= mul_out;
          state_q <= FIX;
        end
`endif
        FIX: begin
          result_q <= neg_q ? (~fix_in + 64'd1) : fix_in;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == DONE) && !annul_i;
  // DONE drops the stall so EX advances with the product that same cycle.
  assign stallreq_o = accept || (state_q == ARR) || (state_q == FIX);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table plus annul, held-start,
// back-to-back and mid-operation reset sequences. Latency follows MUL_PIPE_EN.
module tb_mul_unit;
`ifdef MUL_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_res;

  mul_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and returns with the DUT in DONE.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    check({name, " stall_at_T"}, 64'(stallreq_o), 64'd1);
    step();
    start_i = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      check({name, " stall_busy"}, 64'(stallreq_o), 64'd1);
      check({name, " ready_busy"}, 64'(ready_o), 64'd0);
      check({name, " result_held"}, result_o, last_res);
      step();
    end
    check({name, " ready"}, 64'(ready_o), 64'd1);
    check({name, " stall_done"}, 64'(stallreq_o), 64'd0);
    check({name, " result"}, result_o, exp);
    last_res = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "u_max"};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "s_m1_m1"};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, "s_m1_2"};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, "u_max_2"};
    vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "s_min_min"};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, "s_min_1"};
    vecs[6] = '{1'b1, 32'h80000000, 32'h00000000, 64'h0, "s_min_0"};
    vecs[7] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, "s_m3_5"};
    vecs[8] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "u_min_min"};
    vecs[9] = '{1'b1, 32'h00000007, 32'hFFFFFFF7, 64'hFFFFFFFF_FFFFFFC1, "s_7_m9"};

    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; last_res = '0;
    #12;
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    #10 resetn = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      step();
      check({vecs[i].name, " ready_one_cycle"}, 64'(ready_o), 64'd0);
      check({vecs[i].name, " stall_idle"}, 64'(stallreq_o), 64'd0);
    end

    // start together with annul in IDLE: nothing may start
    signed_i = 1'b0; opdata1_i = 32'd2; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    #1;
    check("start_annul stall", 64'(stallreq_o), 64'd0);
    step();
    start_i = 1'b0; annul_i = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      check("start_annul no_ready", 64'(ready_o), 64'd0);
      check("start_annul no_stall", 64'(stallreq_o), 64'd0);
      step();
    end

    // annul in FIX: operation discarded, result keeps 15
    run_op(1'b0, 32'd3, 32'd5, 64'd15, "pre_annul");
    step();
    opdata1_i = 32'd7; opdata2_i = 32'd9; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (LAT - 2) step();
    annul_i = 1'b1;
    #1;
    check("annul fix_ready", 64'(ready_o), 64'd0);
    step();
    annul_i = 1'b0;
    #1;
    check("annul stall_drop", 64'(stallreq_o), 64'd0);
    for (int k = 0; k <= LAT; k++) begin
      check("annul no_ready", 64'(ready_o), 64'd0);
      check("annul result_kept", result_o, 64'h0000000F);
      step();
    end

    // start held through the operation with changed operands
    signed_i = 1'b0; opdata1_i = 32'd3; opdata2_i = 32'd5; start_i = 1'b1;
    step();
    signed_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'hFFFFFF00;
    for (int k = 1; k < LAT; k++) begin
      check("held_start stall", 64'(stallreq_o), 64'd1);
      step();
    end
    start_i = 1'b0;
    #1;
    check("held_start ready", 64'(ready_o), 64'd1);
    check("held_start result", result_o, 64'd15);
    last_res = 64'd15;
    step();
    // start on the cycle right after DONE
    run_op(1'b0, 32'd6, 32'd7, 64'd42, "back_to_back");
    step();

    // reset pulse during FIX
    signed_i = 1'b1; opdata1_i = 32'h80000000; opdata2_i = 32'h80000000; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (LAT - 2) step();
    resetn = 1'b0;
    #1;
    check("rst_mid result", result_o, 64'd0);
    check("rst_mid ready", 64'(ready_o), 64'd0);
    check("rst_mid stall", 64'(stallreq_o), 64'd0);
    last_res = '0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("rst_mid idle_ready", 64'(ready_o), 64'd0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd9, 64'hFFFFFFFF_FFFFFFC1, "after_reset");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
